// File: rtl/rx_watchdog_pkg.sv
// Purpose: shared constants for the multi-channel receiver watchdog.
// Contents: rst_cause bit positions and FSM state encoding.
// Used by: rx_watchdog_mc (top) and its sub-modules.
package rx_watchdog_pkg;

  // Bit positions inside rst_cause
  localparam int CAUSE_DC   = 0;
  localparam int CAUSE_LEN  = 1;
  localparam int CAUSE_TO   = 2;
  localparam int NUM_CAUSES = 3;

  // Watchdog FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

endpackage

// File: rtl/dc_sign_window.sv
// Purpose: per-channel sign-balance counters for the DC/stuck-sign check.
// Ports: clock/reset; clr_i aborts the window; strobe_i counts a sample;
//   close_i marks the last sample of the window; sample_i = {I, Q};
//   dc_th_i threshold; flag_o = DC verdict including the current sample.
module dc_sign_window #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int WIN_LOG2      = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       strobe_i,
  input  logic                       close_i,
  input  logic [2*IQ_DATA_WIDTH-1:0] sample_i,
  input  logic [WIN_LOG2:0]          dc_th_i,
  output logic                       flag_o
);

  localparam logic [WIN_LOG2:0] WIN_SIZE = {1'b1, {WIN_LOG2{1'b0}}};

  logic              i_pos, q_pos;
  logic [WIN_LOG2:0] pos_i_q, pos_i_d, pos_q_q, pos_q_d;
  logic [WIN_LOG2:0] pos_i_nx, pos_q_nx;
  logic [WIN_LOG2+1:0] lo_lim;
  logic              lo_ok;
  logic              hit_i, hit_q;

  // Only the sign bits matter; magnitude bits are deliberately ignored.
  logic unused_mag;
  assign unused_mag = ^{sample_i[2*IQ_DATA_WIDTH-2:IQ_DATA_WIDTH],
                        sample_i[IQ_DATA_WIDTH-2:0]};

  assign i_pos = ~sample_i[2*IQ_DATA_WIDTH-1];
  assign q_pos = ~sample_i[IQ_DATA_WIDTH-1];

  // Counts as they stand once the current sample is included, so the
  // verdict at close covers all 2^WIN_LOG2 samples of the window.
  assign pos_i_nx = pos_i_q + {{WIN_LOG2{1'b0}}, strobe_i & i_pos};
  assign pos_q_nx = pos_q_q + {{WIN_LOG2{1'b0}}, strobe_i & q_pos};

  // Lower bound 2^W - dc_th; one extra bit so an out-of-range threshold
  // goes negative and disables the "too few positives" test instead of wrapping.
  assign lo_lim = {1'b0, WIN_SIZE} - {1'b0, dc_th_i};
  assign lo_ok  = ~lo_lim[WIN_LOG2+1];

  assign hit_i  = (pos_i_nx >= dc_th_i) | (lo_ok & ({1'b0, pos_i_nx} <= lo_lim));
  assign hit_q  = (pos_q_nx >= dc_th_i) | (lo_ok & ({1'b0, pos_q_nx} <= lo_lim));
  assign flag_o = hit_i | hit_q;

  always_comb begin
    pos_i_d = pos_i_q;
    pos_q_d = pos_q_q;
    if (clr_i || close_i) begin
      pos_i_d = '0;
      pos_q_d = '0;
    end else if (strobe_i) begin
      pos_i_d = pos_i_nx;
      pos_q_d = pos_q_nx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_i_q <= '0;
      pos_q_q <= '0;
    end else begin
      pos_i_q <= pos_i_d;
      pos_q_q <= pos_q_d;
    end
  end

endmodule

// File: rtl/rx_watchdog_mc.sv
// Purpose: multi-channel receiver watchdog (DC/stuck-sign, SIG over-length,
//   demod timeout) driving a fixed-length receiver reset plus hold-off.
// Ports: clock/reset; enable, demod_is_ongoing, sample_in(+_strobe), SIG
//   length inputs, thresholds/modes, cause_clear; outputs receiver_rst,
//   sticky rst_cause, saturating rst_count, per-channel dc_flag.
module rx_watchdog_mc
  import rx_watchdog_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int IQ_DATA_WIDTH = 16,
  parameter int LEN_WIDTH     = 16,
  parameter int WIN_LOG2      = 5,
  parameter int RST_PULSE_LEN = 4,
  parameter int TO_WIDTH      = 24
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              demod_is_ongoing,
  input  logic [2*IQ_DATA_WIDTH*NUM_CH-1:0] sample_in,
  input  logic                              sample_in_strobe,
  input  logic [LEN_WIDTH-1:0]              signal_len,
  input  logic                              sig_valid,
  input  logic [LEN_WIDTH-1:0]              max_signal_len_th,
  input  logic [WIN_LOG2:0]                 dc_th,
  input  logic                              dc_mode,
  input  logic [TO_WIDTH-1:0]               demod_timeout_th,
  input  logic [15:0]                       holdoff_len,
  input  logic                              cause_clear,
  output logic                              receiver_rst,
  output logic [2:0]                        rst_cause,
  output logic [15:0]                       rst_count,
  output logic [NUM_CH-1:0]                 dc_flag
);

  localparam logic [WIN_LOG2:0] WIN_SIZE = {1'b1, {WIN_LOG2{1'b0}}};
  localparam int                PW       = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [PW-1:0]     PULSE_LAST = PW'(RST_PULSE_LEN - 1);

  logic [1:0]            state_q, state_d;
  logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
  logic [NUM_CH-1:0]     dc_flag_q, dc_flag_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic [PW-1:0]         pulse_cnt_q, pulse_cnt_d;
  logic [15:0]           ho_cnt_q, ho_cnt_d;
  logic [2:0]            cause_q, cause_d;
  logic [15:0]           count_q, count_d;
  logic                  rst_q;

  logic                  win_active, win_clr, win_close;
  logic [NUM_CH-1:0]     flags_now;
  logic                  dc_en, dc_hit;
  logic [TO_WIDTH:0]     to_inc;
  logic                  ho_done;
  logic [NUM_CAUSES-1:0] causes;
  logic                  accept;

  // DC window only runs while checking is allowed and nothing is in progress;
  // otherwise it is held at zero so a fresh window starts afterwards.
  assign win_active = enable && (state_q == ST_IDLE);
  assign win_clr    = ~win_active;
  assign win_close  = win_active && sample_in_strobe && (win_cnt_q == '1);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    dc_sign_window #(
      .IQ_DATA_WIDTH(IQ_DATA_WIDTH),
      .WIN_LOG2     (WIN_LOG2)
    ) u_win (
      .clock   (clock),
      .reset   (reset),
      .clr_i   (win_clr),
      .strobe_i(sample_in_strobe),
      .close_i (win_close),
      .sample_i(sample_in[2*IQ_DATA_WIDTH*k +: 2*IQ_DATA_WIDTH]),
      .dc_th_i (dc_th),
      .flag_o  (flags_now[k])
    );
  end

  assign dc_en  = (dc_th != '0) && (dc_th <= WIN_SIZE);
  assign dc_hit = dc_mode ? (&flags_now) : (|flags_now);

  // Extra bit keeps to_cnt+1 from wrapping into a false match.
  assign to_inc = {1'b0, to_cnt_q} + 1'b1;

  assign causes[CAUSE_DC]  = win_close && dc_en && dc_hit;
  assign causes[CAUSE_LEN] = sig_valid && (max_signal_len_th != '0) &&
                             (signal_len > max_signal_len_th);
  assign causes[CAUSE_TO]  = sample_in_strobe && demod_is_ongoing &&
                             (demod_timeout_th != '0) &&
                             (to_inc == {1'b0, demod_timeout_th});

  assign accept  = (state_q == ST_IDLE) && (|causes);
  assign ho_done = ({1'b0, ho_cnt_q} + 17'd1) >= {1'b0, holdoff_len};

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (!win_active)           win_cnt_d = '0;
    else if (sample_in_strobe) win_cnt_d = win_cnt_q + 1'b1;  // wraps to 0 at close
  end

  assign dc_flag_d = win_close ? flags_now : dc_flag_q;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (accept || !demod_is_ongoing) to_cnt_d = '0;
    else if (sample_in_strobe)       to_cnt_d = to_cnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    ho_cnt_d    = ho_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_PULSE;
          pulse_cnt_d = '0;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          ho_cnt_d = '0;
          state_d  = (holdoff_len == 16'd0) ? ST_IDLE : ST_HOLDOFF;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (sample_in_strobe) begin
          if (ho_done) state_d  = ST_IDLE;
          else         ho_cnt_d = ho_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear happens before set so a same-cycle trigger survives cause_clear.
  always_comb begin
    cause_d = cause_clear ? 3'b000 : cause_q;
    if (accept) cause_d = cause_d | causes;
  end

  always_comb begin
    count_d = count_q;
    if (accept && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      win_cnt_q   <= '0;
      dc_flag_q   <= '0;
      to_cnt_q    <= '0;
      pulse_cnt_q <= '0;
      ho_cnt_q    <= '0;
      cause_q     <= '0;
      count_q     <= '0;
      rst_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      dc_flag_q   <= dc_flag_d;
      to_cnt_q    <= to_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      ho_cnt_q    <= ho_cnt_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      rst_q       <= (state_d == ST_PULSE);
    end
  end

  assign receiver_rst = rst_q;
  assign rst_cause    = cause_q;
  assign rst_count    = count_q;
  assign dc_flag      = dc_flag_q;

endmodule

// File: tb/tb_rx_watchdog_mc.sv
module tb_rx_watchdog_mc;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable, demod_is_ongoing;
  logic [63:0] sample_in;
  logic        sample_in_strobe;
  logic [15:0] signal_len;
  logic        sig_valid;
  logic [15:0] max_signal_len_th;
  logic [5:0]  dc_th;
  logic        dc_mode;
  logic [23:0] demod_timeout_th;
  logic [15:0] holdoff_len;
  logic        cause_clear;
  logic        receiver_rst;
  logic [2:0]  rst_cause;
  logic [15:0] rst_count;
  logic [1:0]  dc_flag;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  logic [2:0] exp_cause;

  typedef struct {
    logic [15:0] th;
    logic [15:0] len;
    logic        trig;
  } len_vec_t;

  len_vec_t vecs[7];

  rx_watchdog_mc #(
    .NUM_CH(2), .IQ_DATA_WIDTH(16), .LEN_WIDTH(16),
    .WIN_LOG2(5), .RST_PULSE_LEN(4), .TO_WIDTH(24)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .demod_is_ongoing (demod_is_ongoing),
    .sample_in        (sample_in),
    .sample_in_strobe (sample_in_strobe),
    .signal_len       (signal_len),
    .sig_valid        (sig_valid),
    .max_signal_len_th(max_signal_len_th),
    .dc_th            (dc_th),
    .dc_mode          (dc_mode),
    .demod_timeout_th (demod_timeout_th),
    .holdoff_len      (holdoff_len),
    .cause_clear      (cause_clear),
    .receiver_rst     (receiver_rst),
    .rst_cause        (rst_cause),
    .rst_count        (rst_count),
    .dc_flag          (dc_flag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ch0 always I=+1000/Q=+500; ch1 the same, or sign-alternating when alt1 is set
  function automatic logic [63:0] mk(input bit alt1, input int idx);
    logic [15:0] pi, pq, ni, nq;
    pi = 16'd1000; pq = 16'd500; ni = 16'hFC18; nq = 16'hFE0C;
    if (alt1 && idx[0]) return {ni, nq, pi, pq};
    return {pi, pq, pi, pq};
  endfunction

  task automatic run_win(input int start, input int n, input bit alt1);
    for (int k = 0; k < n; k++) begin
      sample_in        = mk(alt1, start + k);
      sample_in_strobe = 1'b1;
      @(negedge clock);
    end
    sample_in_strobe = 1'b0;
  endtask

  // Counts receiver_rst high cycles over a bounded 12-cycle span from now
  task automatic pulse_width(output int w);
    w = 0;
    for (int i = 0; i < 12; i++) begin
      if (receiver_rst) w++;
      @(negedge clock);
    end
  endtask

  task automatic ovl(input logic [15:0] len);
    sig_valid  = 1'b1;
    signal_len = len;
    @(negedge clock);
    sig_valid  = 1'b0;
  endtask

  task automatic clear_cause();
    cause_clear = 1'b1;
    @(negedge clock);
    cause_clear = 1'b0;
    exp_cause   = 3'b000;
  endtask

  initial begin
    int w;
    reset = 1'b1; enable = 1'b0; demod_is_ongoing = 1'b0;
    sample_in = '0; sample_in_strobe = 1'b0; signal_len = '0; sig_valid = 1'b0;
    max_signal_len_th = '0; dc_th = '0; dc_mode = 1'b0; demod_timeout_th = '0;
    holdoff_len = '0; cause_clear = 1'b0; exp_cause = 3'b000;
    cyc(2);
    chk("reset_rst", 32'(receiver_rst), 0);
    chk("reset_cause", 32'(rst_cause), 0);
    chk("reset_count", 32'(rst_count), 0);
    chk("reset_dcflag", 32'(dc_flag), 0);
    reset = 1'b0;
    cyc(1);

    // 1: DC, any-channel mode
    enable = 1'b1; dc_th = 6'd28; dc_mode = 1'b0;
    run_win(0, 31, 1'b1);
    chk("dc1_before_close", 32'(receiver_rst), 0);
    run_win(31, 1, 1'b1);
    exp_count++; exp_cause = 3'b001;
    chk("dc1_flag", 32'(dc_flag), 1);
    chk("dc1_cause", 32'(rst_cause), 32'(exp_cause));
    chk("dc1_count", 32'(rst_count), 32'(exp_count));
    chk("dc1_rst_now", 32'(receiver_rst), 1);
    pulse_width(w);
    chk("dc1_pulse_width", 32'(w), 4);

    // 2: DC, all-channel mode
    dc_mode = 1'b1;
    run_win(0, 32, 1'b1);
    chk("dc2_alt_norst", 32'(receiver_rst), 0);
    chk("dc2_alt_flag", 32'(dc_flag), 1);
    chk("dc2_alt_count", 32'(rst_count), 32'(exp_count));
    run_win(0, 32, 1'b0);
    exp_count++;
    chk("dc2_const_rst", 32'(receiver_rst), 1);
    chk("dc2_const_flag", 32'(dc_flag), 3);
    chk("dc2_const_count", 32'(rst_count), 32'(exp_count));
    cyc(6);

    // 3: over-length table
    enable = 1'b0; dc_mode = 1'b0;
    clear_cause();
    chk("len_cleared", 32'(rst_cause), 0);
    vecs[0] = '{16'd3000,  16'd3000,  1'b0};
    vecs[1] = '{16'd3000,  16'd4000,  1'b1};
    vecs[2] = '{16'd3000,  16'd3001,  1'b1};
    vecs[3] = '{16'd3000,  16'd2999,  1'b0};
    vecs[4] = '{16'd0,     16'd65535, 1'b0};
    vecs[5] = '{16'd65534, 16'd65535, 1'b1};
    vecs[6] = '{16'd65535, 16'd65535, 1'b0};
    for (int v = 0; v < 7; v++) begin
      max_signal_len_th = vecs[v].th;
      ovl(vecs[v].len);
      if (vecs[v].trig) begin
        exp_count++;
        exp_cause = exp_cause | 3'b010;
      end
      chk($sformatf("len%0d_rst", v), 32'(receiver_rst), 32'(vecs[v].trig));
      chk($sformatf("len%0d_cause", v), 32'(rst_cause), 32'(exp_cause));
      chk($sformatf("len%0d_count", v), 32'(rst_count), 32'(exp_count));
      cyc(6);
    end
    max_signal_len_th = 16'd3000;

    // 4: demod timeout
    clear_cause();
    demod_timeout_th = 24'd100; demod_is_ongoing = 1'b1;
    run_win(0, 99, 1'b0);
    chk("to_99_norst", 32'(receiver_rst), 0);
    run_win(0, 1, 1'b0);
    exp_count++;
    chk("to_100_rst", 32'(receiver_rst), 1);
    chk("to_100_cause", 32'(rst_cause), 4);
    chk("to_100_count", 32'(rst_count), 32'(exp_count));
    demod_is_ongoing = 1'b0;
    cyc(6);
    demod_is_ongoing = 1'b1;
    run_win(0, 98, 1'b0);
    demod_is_ongoing = 1'b0;
    run_win(0, 1, 1'b0);
    demod_is_ongoing = 1'b1;
    run_win(0, 99, 1'b0);
    chk("to_restart_norst", 32'(receiver_rst), 0);
    chk("to_restart_count", 32'(rst_count), 32'(exp_count));
    run_win(0, 1, 1'b0);
    exp_count++;
    chk("to_restart_rst", 32'(receiver_rst), 1);
    demod_is_ongoing = 1'b0;
    demod_timeout_th = '0;
    cyc(6);

    // 5: simultaneous causes, hold-off, clear
    clear_cause();
    enable = 1'b1; dc_th = 6'd28; dc_mode = 1'b0; holdoff_len = 16'd10;
    run_win(0, 31, 1'b0);
    sig_valid = 1'b1; signal_len = 16'd4000;
    run_win(31, 1, 1'b0);
    sig_valid = 1'b0;
    enable = 1'b0;
    exp_count++;
    chk("sim_cause", 32'(rst_cause), 3);
    chk("sim_count", 32'(rst_count), 32'(exp_count));
    cyc(4);
    chk("sim_pulse_end", 32'(receiver_rst), 0);
    for (int k = 1; k <= 9; k++) begin
      sample_in_strobe = 1'b1;
      sig_valid        = (k == 5);
      @(negedge clock);
    end
    sample_in_strobe = 1'b0;
    sig_valid        = 1'b0;
    chk("ho_ignored_count", 32'(rst_count), 32'(exp_count));
    chk("ho_ignored_cause", 32'(rst_cause), 3);
    ovl(16'd4000);
    chk("ho_9strobes_norst", 32'(receiver_rst), 0);
    run_win(0, 1, 1'b0);
    cause_clear = 1'b1; holdoff_len = 16'd0;
    ovl(16'd4000);
    cause_clear = 1'b0;
    exp_count++;
    chk("ho_done_rst", 32'(receiver_rst), 1);
    chk("clr_and_set_cause", 32'(rst_cause), 2);
    chk("ho_done_count", 32'(rst_count), 32'(exp_count));
    cyc(6);
    clear_cause();
    chk("clear_cause", 32'(rst_cause), 0);

    // 6: async reset mid-pulse, then counter saturation
    ovl(16'd4000);
    chk("mid_pulse_rst", 32'(receiver_rst), 1);
    cyc(1);
    reset = 1'b1;
    #1;
    chk("async_rst_out", 32'(receiver_rst), 0);
    chk("async_rst_count", 32'(rst_count), 0);
    chk("async_rst_cause", 32'(rst_cause), 0);
    @(negedge clock);
    reset = 1'b0;
    cyc(1);
    // Preload the counter near its ceiling instead of issuing 65533 triggers
    force dut.count_q = 16'd65533;
    @(negedge clock);
    release dut.count_q;
    cyc(1);
    exp_count = 65533;
    for (int t = 0; t < 4; t++) begin
      ovl(16'd4000);
      if (exp_count < 65535) exp_count++;
      chk($sformatf("sat%0d_count", t), 32'(rst_count), 32'(exp_count));
      cyc(6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
